stream_xor_cipher: RTL and testbench
====================================

# stream_xor_cipher

Parametrised stream-cipher datapath that XORs a data stream with a keystream from the RC4 keystream generator, using valid/ready handshakes on all three streams. It sequences generator start-up, buffers keystream words in a small FIFO, and registers the output. Encryption and decryption are the same XOR operation. It replaces the fixed-width, handshake-less encrypt wrapper and sits between the text source and the channel modulator.

## Interface
- W, 7: data and keystream word width in bits.
- DEPTH, 4: keystream FIFO depth in words; must be a power of 2 and at least 2.
- CNT_W, 16: width of the processed-word counter.

- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (reset when rst==0 at a clk edge).
- start  in  1  one-cycle request to begin a session; honoured only in IDLE.
- abort  in  1  ends the session from any non-IDLE state.
- gen_start  out  1  one-cycle pulse telling the generator to (re)initialise.
- gen_init_done  in  1  level from the generator; 1 once its key schedule is complete.
- ks_data  in  W  keystream word.
- ks_valid  in  1  ks_data is valid.
- ks_ready  out  1  block accepts the keystream word this cycle.
- in_data  in  W  plaintext or ciphertext word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  W  value of in_data XOR the keystream word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  state is not IDLE.
- word_count  out  CNT_W  number of words transferred on the input side since the last accepted start; wraps modulo 2^CNT_W.

## Operation
- FSM states:
  - IDLE
    - start=1 -> INIT. On that edge: gen_start=1 for one cycle, word_count cleared, FIFO cleared.
  - INIT
    - ks_ready=0, in_ready=0.
    - gen_init_done=1 -> RUN.
    - abort=1 -> FLUSH. Abort has priority over gen_init_done.
  - RUN
    - ks_ready = (FIFO not full).
    - in_ready = (FIFO not empty) && (!out_valid || out_ready).
    - abort=1 -> FLUSH.
    - start is ignored.
  - FLUSH
    - Lasts one cycle. FIFO cleared, out_valid cleared, ks_ready=0, in_ready=0.
    - Next state is IDLE.
- Keystream push: ks_valid && ks_ready writes ks_data to the FIFO tail.
- Data transfer: in_valid && in_ready does all of the following on the same edge:
  - pops the FIFO head;
  - out_data <= in_data ^ head;
  - out_valid <= 1;
  - word_count <= word_count + 1.
- Output hold: out_valid && !out_ready holds out_data stable; no new transfer occurs.
- Output clear: out_ready with no new transfer clears out_valid.
- Push and pop in the same cycle are both performed; the FIFO occupancy is unchanged.
- ks_ready depends only on occupancy before the edge. A full FIFO refuses a push even if a pop happens in the same cycle.
- Keystream words are consumed strictly in arrival order. No keystream word is ever used twice or skipped.
- word_count holds its value through FLUSH and IDLE until the next accepted start.

## Timing
- Reset values: state IDLE, FIFO empty, gen_start=0, ks_ready=0, in_ready=0, out_valid=0, out_data=0, busy=0, word_count=0.
- Reset mid-session behaves like abort but also zeroes out_data and word_count; no gen_start is issued.
- gen_start is high in the cycle after the start edge. INIT is entered on that same edge.
- RUN is entered one edge after gen_init_done is first sampled high in INIT.
- Latency: out_valid is high in the cycle after the transfer edge.
- Throughput: one word per cycle while the FIFO is non-empty and out_ready=1.
- A keystream word pushed at edge t can be consumed no earlier than edge t+1.
- in_ready, ks_ready and busy are combinational from state, FIFO occupancy, out_valid and out_ready. No output depends combinationally on in_valid or ks_valid.
- abort and start in the same IDLE cycle: start wins; abort is ignored in IDLE.

## Test plan
- Reset with rst=0 for 2 cycles, all inputs toggling -> every output equals its reset value; busy=0.
- start, gen_init_done high 3 cycles later, ks words 0x15, 0x2A; in words 0x41, 0x00, out_ready=1 -> out_data 0x54 then 0x2A, each one cycle after transfer; word_count=2; gen_start pulsed exactly once.
- DEPTH=4, ks_valid held high, in_valid=0 -> ks_ready falls after 4 pushes. Then one in transfer with a simultaneous ks push -> occupancy stays 4 and the next ks_ready=0.
- out_ready=0 for 5 cycles with out_valid=1 -> out_data stable, in_ready=0, no FIFO pop. On out_ready=1 the stream resumes with no loss or duplication.
- abort in RUN with 3 words buffered and out_valid=1 -> FLUSH one cycle, then IDLE. FIFO empty, out_valid=0, word_count unchanged. A new start clears word_count and re-pulses gen_start.
- Round trip: two instances share the same keystream sequence, and the first instance's output feeds the second -> the second's output equals the original data for 64 random 7-bit words.

Source files
------------

// File: rtl/stream_xor_cipher.sv
// stream_xor_cipher
// XORs a data stream with RC4 keystream words under valid/ready handshakes.
// A small FIFO decouples keystream arrival from data arrival; the output
// word is registered. The same datapath encrypts and decrypts.
module stream_xor_cipher #(
    parameter int W     = 7,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             gen_start,
    input  logic             gen_init_done,
    input  logic [W-1:0]     ks_data,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] word_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]    PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]    PTR_ZERO = {(AW+1){1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t state_r;
    state_t state_next_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [W-1:0]     fifo_mem_r [DEPTH];
    logic [W-1:0]     head_s;
    logic             empty_s;
    logic             full_s;
    logic             fifo_clr_s;
    logic             ks_ready_s;
    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             gen_start_r;
    logic             out_valid_r;
    logic [W-1:0]     out_data_r;
    logic [CNT_W-1:0] word_count_r;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head_s  = fifo_mem_r[rd_ptr_r[AW-1:0]];
    assign push_s  = ks_valid && ks_ready_s;
    assign pop_s   = in_valid && in_ready_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; abort outranks gen_init_done in INIT, start is only seen in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:  state_next_s = start ? S_INIT : S_IDLE;
            S_INIT:  state_next_s = abort ? S_FLUSH : (gen_init_done ? S_RUN : S_INIT);
            S_RUN:   state_next_s = abort ? S_FLUSH : S_RUN;
            S_FLUSH: state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Handshake readies and FIFO clear, from state, occupancy and output register only.
    always_comb begin
        ks_ready_s = 1'b0;
        in_ready_s = 1'b0;
        fifo_clr_s = 1'b0;
        case (state_r)
            S_IDLE:  fifo_clr_s = start;
            S_INIT:  fifo_clr_s = 1'b0;
            S_RUN: begin
                ks_ready_s = !full_s;
                in_ready_s = !empty_s && (!out_valid_r || out_ready);
            end
            S_FLUSH: fifo_clr_s = 1'b1;
            default: fifo_clr_s = 1'b1;
        endcase
    end

    // FIFO pointers: cleared at session start and in FLUSH, otherwise push/pop independently.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else if (fifo_clr_s) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= ks_data;
        end
    end

    // One-cycle generator start pulse on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gen_start_r <= 1'b0;
        end else begin
            gen_start_r <= (state_r == S_IDLE) && start;
        end
    end

    // Output register: load on transfer, hold while stalled, drop when consumed or flushed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
        end else if (state_r == S_FLUSH) begin
            out_valid_r <= 1'b0;
        end else if (pop_s) begin
            out_data_r  <= in_data ^ head_s;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Input-side word counter; survives FLUSH/IDLE until the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_count_r <= CNT_ZERO;
        end else if ((state_r == S_IDLE) && start) begin
            word_count_r <= CNT_ZERO;
        end else if (pop_s) begin
            word_count_r <= word_count_r + CNT_ONE;
        end
    end

    assign gen_start  = gen_start_r;
    assign ks_ready   = ks_ready_s;
    assign in_ready   = in_ready_s;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign busy       = (state_r != S_IDLE);
    assign word_count = word_count_r;

endmodule

// File: tb/tb_stream_xor_cipher.sv
// Scoreboard bench for stream_xor_cipher: directed vectors on instance A,
// then a round trip A -> B sharing one keystream sequence.
module tb_stream_xor_cipher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, abort_a, gid_a, ksv_a, inv_a;
    logic [6:0]  ksd_a, ind_a;
    logic        gen_start_a, ks_ready_a, in_ready_a, out_valid_a, busy_a;
    logic [6:0]  out_data_a;
    logic [15:0] word_count_a;
    logic        tb_out_ready, rt_mode;
    logic        out_ready_a;

    logic        start_b, gid_b, ksv_b;
    logic [6:0]  ksd_b;
    logic        gen_start_b, ks_ready_b, in_ready_b, out_valid_b, busy_b;
    logic [6:0]  out_data_b;
    logic [15:0] word_count_b;

    assign out_ready_a = rt_mode ? in_ready_b : tb_out_ready;

    stream_xor_cipher #(.W(7), .DEPTH(4), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .gen_start(gen_start_a), .gen_init_done(gid_a),
        .ks_data(ksd_a), .ks_valid(ksv_a), .ks_ready(ks_ready_a),
        .in_data(ind_a), .in_valid(inv_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .busy(busy_a), .word_count(word_count_a)
    );

    stream_xor_cipher #(.W(7), .DEPTH(4), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(1'b0),
        .gen_start(gen_start_b), .gen_init_done(gid_b),
        .ks_data(ksd_b), .ks_valid(ksv_b), .ks_ready(ks_ready_b),
        .in_data(out_data_a), .in_valid(out_valid_a), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(1'b1),
        .busy(busy_b), .word_count(word_count_b)
    );

    logic [6:0] exp_a[$];
    logic [6:0] exp_b[$];
    int n_cmp = 0;
    int n_fail = 0;
    int gs_cnt_a = 0;
    logic [6:0] rt_d [64];
    logic [6:0] rt_k [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // which: 0 = ks A, 1 = ks B, 2 = in A. Returns after the accepting edge (+1).
    task automatic wait_hs(input int which, input string name, output bit ok);
        logic rdy;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            case (which)
                0:       rdy = ks_ready_a;
                1:       rdy = ks_ready_b;
                default: rdy = in_ready_a;
            endcase
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no ready expected ready within 100 cycles", name);
        end
    endtask

    task automatic push_ks(input int which, input logic [6:0] k);
        bit ok;
        if (which == 0) begin ksv_a = 1'b1; ksd_a = k; end
        else            begin ksv_b = 1'b1; ksd_b = k; end
        wait_hs(which, (which == 0) ? "ks_a" : "ks_b", ok);
        if (which == 0) ksv_a = 1'b0;
        else            ksv_b = 1'b0;
    endtask

    task automatic send_in(input logic [6:0] d, input logic [6:0] k, input bit expect_out);
        bit ok;
        inv_a = 1'b1;
        ind_a = d;
        wait_hs(2, "in_a", ok);
        inv_a = 1'b0;
        if (ok) begin
            if (expect_out) exp_a.push_back(d ^ k);
            check("latency_out_valid", out_valid_a, 1);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output handshake and counts gen_start pulses.
    always @(negedge clk) begin : monitor
        logic [6:0] e;
        if (gen_start_a === 1'b1) gs_cnt_a++;
        if (out_valid_a === 1'b1 && out_ready_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL out_a_unexpected: got 0x%0h expected no output", out_data_a);
            end else begin
                e = exp_a.pop_front();
                check("out_a", out_data_a, e);
            end
        end
        if (out_valid_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL out_b_unexpected: got 0x%0h expected no output", out_data_b);
            end else begin
                e = exp_b.pop_front();
                check("out_b", out_data_b, e);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300000");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit ok;
        rst = 1'b0; rt_mode = 1'b0; tb_out_ready = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; gid_a = 1'b0; ksv_a = 1'b0; inv_a = 1'b0;
        ksd_a = 7'h00; ind_a = 7'h00;
        start_b = 1'b0; gid_b = 1'b0; ksv_b = 1'b0; ksd_b = 7'h00;

        // Reset for 2 cycles with inputs toggling.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start_a = ~start_a; abort_a = ~abort_a; gid_a = ~gid_a; ksv_a = ~ksv_a;
            inv_a = ~inv_a; tb_out_ready = ~tb_out_ready; ksd_a = 7'h55; ind_a = 7'h2A;
        end
        tick();
        check("rst_gen_start", gen_start_a, 0);
        check("rst_ks_ready", ks_ready_a, 0);
        check("rst_in_ready", in_ready_a, 0);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_word_count", word_count_a, 0);
        start_a = 1'b0; abort_a = 1'b0; gid_a = 1'b0; ksv_a = 1'b0; inv_a = 1'b0;
        tb_out_ready = 1'b1;
        rst = 1'b1;
        tick();
        gs_cnt_a = 0;

        // Basic session: keystream 0x15,0x2A against data 0x41,0x00.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("start_gen_start", gen_start_a, 1);
        check("start_busy", busy_a, 1);
        check("start_in_ready_init", in_ready_a, 0);
        tick();
        check("gen_start_one_cycle", gen_start_a, 0);
        tick(); tick();
        gid_a = 1'b1;
        tick();
        check("run_ks_ready", ks_ready_a, 1);
        check("run_in_ready_empty", in_ready_a, 0);
        push_ks(0, 7'h15);
        push_ks(0, 7'h2A);
        send_in(7'h41, 7'h15, 1'b1);
        send_in(7'h00, 7'h2A, 1'b1);
        tick();
        check("basic_word_count", word_count_a, 2);
        check("basic_gen_start_pulses", gs_cnt_a, 1);

        // Fill the FIFO with ks_valid held high.
        acc = 0;
        ksv_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ksd_a = 7'(acc + 1);
            @(negedge clk);
            if (ks_ready_a === 1'b1) acc++;
            tick();
        end
        check("fill_push_count", acc, 4);
        check("fill_ks_ready_full", ks_ready_a, 0);
        // Full: transfer while a push is offered; push must be refused.
        ksd_a = 7'h05; inv_a = 1'b1; ind_a = 7'h10;
        @(negedge clk);
        check("full_ks_ready", ks_ready_a, 0);
        check("full_in_ready", in_ready_a, 1);
        tick();
        exp_a.push_back(7'h11);
        // Occupancy 3: simultaneous push and pop.
        ind_a = 7'h20;
        @(negedge clk);
        check("pushpop_ks_ready", ks_ready_a, 1);
        check("pushpop_in_ready", in_ready_a, 1);
        tick();
        exp_a.push_back(7'h22);
        inv_a = 1'b0; ksd_a = 7'h06;
        @(negedge clk);
        check("refill_ks_ready", ks_ready_a, 1);
        tick();
        ksv_a = 1'b0;
        @(negedge clk);
        check("occupancy_after_pushpop", ks_ready_a, 0);
        tick();
        check("fill_word_count", word_count_a, 4);

        // Output stall: out_ready low for 5 cycles.
        tb_out_ready = 1'b0;
        send_in(7'h30, 7'h03, 1'b1);
        inv_a = 1'b1; ind_a = 7'h40;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid_a, 1);
            check("stall_out_data", out_data_a, 7'h33);
            check("stall_in_ready", in_ready_a, 0);
            tick();
        end
        tb_out_ready = 1'b1;
        send_in(7'h40, 7'h04, 1'b1);
        check("stall_word_count", word_count_a, 6);
        tick();

        // Abort with 3 words buffered and an undelivered output.
        tb_out_ready = 1'b0;
        send_in(7'h50, 7'h05, 1'b0);
        push_ks(0, 7'h07);
        push_ks(0, 7'h08);
        check("pre_abort_out_valid", out_valid_a, 1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("flush_busy", busy_a, 1);
        check("flush_ks_ready", ks_ready_a, 0);
        check("flush_in_ready", in_ready_a, 0);
        tick();
        check("idle_busy", busy_a, 0);
        check("idle_out_valid", out_valid_a, 0);
        check("idle_word_count_held", word_count_a, 7);
        tb_out_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("restart_word_count", word_count_a, 0);
        check("restart_gen_start", gen_start_a, 1);
        tick();
        check("restart_busy", busy_a, 1);
        check("restart_fifo_empty", in_ready_a, 0);
        push_ks(0, 7'h11);
        send_in(7'h22, 7'h11, 1'b1);
        tick();
        check("restart_gen_start_pulses", gs_cnt_a, 2);

        // Round trip: A encrypts, B decrypts with the same keystream.
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        tick();
        for (int i = 0; i < 64; i++) begin
            rt_d[i] = 7'($urandom_range(0, 127));
            rt_k[i] = 7'($urandom_range(0, 127));
        end
        rt_mode = 1'b1;
        gid_b = 1'b1;
        start_a = 1'b1; start_b = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        tick();
        fork
            for (int i = 0; i < 64; i++) push_ks(0, rt_k[i]);
            for (int j = 0; j < 64; j++) push_ks(1, rt_k[j]);
            for (int m = 0; m < 64; m++) begin
                send_in(rt_d[m], rt_k[m], 1'b1);
                exp_b.push_back(rt_d[m]);
            end
        join
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (exp_b.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("rt_drained", ok, 1);
        check("rt_exp_a_empty", exp_a.size(), 0);
        check("rt_word_count_a", word_count_a, 64);
        check("rt_word_count_b", word_count_b, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
